// File: rtl/seven_seg_capture_pkg.sv
// Shared definitions for the seven-segment capture path: capture FSM states
// and the active-low segment codes (seg_n[7:1], bit1=a ... bit7=g) for each
// hex digit, which the encoder side reuses.
package seven_seg_capture_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // strobes not exactly one-hot, nothing to capture
        ST_QUAL = 2'd1,  // one-hot strobe, waiting for the sample to settle
        ST_CAPT = 2'd2,  // single cycle in which the digit registers were written
        ST_HOLD = 2'd3   // pattern already captured, wait for it to change
    } state_t;

    // Active-low segment codes, seg_n[7:1]
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational inverse of the hex->segment encoder: maps an active-low
// segment pattern to its nibble and reports whether the pattern is one of
// the sixteen legal hex glyphs.
module seven_seg_decode
    import seven_seg_capture_pkg::*;
(
    input  logic [7:1] i_seg_n,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    // Pattern lookup; anything outside the glyph table (blank included) is illegal
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        o_legal  = 1'b1;
        o_nibble = 4'h0;
        case (i_seg_n)
            SEG_0:   o_nibble = 4'h0;
            SEG_1:   o_nibble = 4'h1;
            SEG_2:   o_nibble = 4'h2;
            SEG_3:   o_nibble = 4'h3;
            SEG_4:   o_nibble = 4'h4;
            SEG_5:   o_nibble = 4'h5;
            SEG_6:   o_nibble = 4'h6;
            SEG_7:   o_nibble = 4'h7;
            SEG_8:   o_nibble = 4'h8;
            SEG_9:   o_nibble = 4'h9;
            SEG_A:   o_nibble = 4'hA;
            SEG_B:   o_nibble = 4'hB;
            SEG_C:   o_nibble = 4'hC;
            SEG_D:   o_nibble = 4'hD;
            SEG_E:   o_nibble = 4'hE;
            SEG_F:   o_nibble = 4'hF;
            default: o_legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Display-bus readback: synchronises the multiplexed active-low segment and
// strobe lines, waits for a strobe/segment pattern to be stable, and latches
// the decoded nibble (or an error flag) for the strobed digit. A frame pulse
// marks the point where every digit has been captured at least once.
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:1]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update,
    output logic                    frame_done
);

    localparam int         IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int         SAMP_W   = NUM_DIGITS + 7;
    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_QUAL = 8'(STABLE_CYCLES - 1);

    // Sample layout: {dig_en_n, seg_n}; all-ones is the idle/blank bus
    logic [SAMP_W-1:0]     r_sync1;
    logic [SAMP_W-1:0]     r_sync2;
    logic [SAMP_W-1:0]     r_prev;
    logic [7:0]            r_cnt;
    state_t                r_state;
    logic [NUM_DIGITS-1:0] r_mask;

    logic [4*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_err;
    logic                    r_update;
    logic                    r_frame_done;

    logic [NUM_DIGITS-1:0] w_dig;
    logic [6:0]            w_seg;
    logic                  w_changed;
    logic                  w_one_hot;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_legal;
    logic [3:0]            w_nibble;
    logic [NUM_DIGITS-1:0] w_mask_next;
    state_t                w_chg_state;

    assign w_dig       = ~r_sync2[SAMP_W-1:7];
    assign w_seg       = r_sync2[6:0];
    assign w_changed   = (r_sync2 != r_prev);
    assign w_one_hot   = (w_dig != '0) && ((w_dig & (w_dig - NUM_DIGITS'(1))) == '0);
    assign w_mask_next = r_mask | w_dig;
    // Any sample change restarts qualification, or drops to idle if the strobes are no longer one-hot
    assign w_chg_state = w_one_hot ? ST_QUAL : ST_IDLE;

    assign hex_out     = r_hex;
    assign digit_valid = r_valid;
    assign digit_err   = r_err;
    assign update      = r_update;
    assign frame_done  = r_frame_done;

    seven_seg_decode u_decode (
        .i_seg_n  (w_seg),
        .o_legal  (w_legal),
        .o_nibble (w_nibble)
    );

    // Strobe index encoder; only meaningful while the strobes are one-hot
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_dig[i]) w_idx = IDX_W'(i);
        end
    end

    // Two-flop synchroniser plus one-sample history for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value.
            r_sync1 <= {dig_en_n, seg_n};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Stability counter: clears on any sample change, otherwise saturating count-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_changed) begin
            r_cnt <= '0;
        end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Capture FSM with registered digit data, status flags, pulses and frame mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mask       <= '0;
            r_hex        <= '0;
            r_valid      <= '0;
            r_err        <= '0;
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_changed && w_one_hot) r_state <= ST_QUAL;
                end
                ST_QUAL: begin
                    if (w_changed) begin
                        r_state <= w_chg_state;
                    end else if (r_cnt >= CNT_QUAL) begin
                        // Capture: the write lands on this edge so update is high during CAPT
                        r_state  <= ST_CAPT;
                        r_update <= 1'b1;
                        if (w_legal) begin
                            r_hex[w_idx*4 +: 4] <= w_nibble;
                            r_valid[w_idx]      <= 1'b1;
                            r_err[w_idx]        <= 1'b0;
                        end else begin
                            r_valid[w_idx]      <= 1'b0;
                            r_err[w_idx]        <= 1'b1;
                        end
                        if (w_mask_next == {NUM_DIGITS{1'b1}}) begin
                            r_frame_done <= 1'b1;
                            r_mask       <= '0;
                        end else begin
                            r_mask       <= w_mask_next;
                        end
                    end
                end
                ST_CAPT: begin
                    r_state <= w_changed ? w_chg_state : ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_changed) r_state <= w_chg_state;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
// Stimulus pushes the expected register state for every capture it causes;
// a negedge monitor pops and compares whenever update is seen.
module tb_seven_seg_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:1]    seg_n = 7'h7F;
    logic [ND-1:0] dig_en_n = '1;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0] digit_valid;
    logic [ND-1:0] digit_err;
    logic          update;
    logic          frame_done;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  valid;
        logic [3:0]  err;
        logic        fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_updates = 0;
    int   n_frames  = 0;

    seven_seg_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_en_n    (dig_en_n),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .update      (update),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] hex, input logic [3:0] valid,
                        input logic [3:0] err, input logic fd);
        exp_t e;
        e.hex   = hex;
        e.valid = valid;
        e.err   = err;
        e.fd    = fd;
        sb_q.push_back(e);
    endtask

    // Inputs change #1 after a rising edge; tasks leave time at edge+1
    task automatic drive(input logic [3:0] d, input logic [7:1] s);
        dig_en_n = d;
        seg_n    = s;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts rising edges until update is seen, bounded by budget
    task automatic measure_latency(input string name, input int budget);
        int lat;
        lat = 0;
        while (lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
            if (update) break;
        end
        check(name, lat, SC + 3);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_hex"},   hex_out,     0);
        check({tag, "_valid"}, digit_valid, 0);
        check({tag, "_err"},   digit_err,   0);
        check({tag, "_upd"},   update,      0);
        check({tag, "_fd"},    frame_done,  0);
    endtask

    // Monitor: every update pops one expectation; frame_done must ride on an update
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (update) begin
                n_updates++;
                if (frame_done) n_frames++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_update: hex_out=%0h valid=%b err=%b with nothing expected",
                             hex_out, digit_valid, digit_err);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_hex",   hex_out,     e.hex);
                    check("sb_valid", digit_valid, e.valid);
                    check("sb_err",   digit_err,   e.err);
                    check("sb_fd",    frame_done,  e.fd);
                end
            end else if (frame_done) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_without_update: frame_done=1 update=0");
            end
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_upd;
        int base_frm;

        // 1. Reset state and first-capture latency
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_zero_outputs("reset");
        hold(2);
        push(16'h0002, 4'b0001, 4'b0000, 1'b0);
        drive(4'b1110, 7'h24);
        measure_latency("t1_latency", 20);
        hold(3);

        // 2. Scan all digits: 79,30,12,0E -> F531, one frame pulse on digit 3
        base_upd = n_updates;
        base_frm = n_frames;
        push(16'h0001, 4'b0001, 4'b0000, 1'b0);
        drive(4'b1110, 7'h79);
        hold(10);
        push(16'h0031, 4'b0011, 4'b0000, 1'b0);
        drive(4'b1101, 7'h30);
        hold(10);
        push(16'h0531, 4'b0111, 4'b0000, 1'b0);
        drive(4'b1011, 7'h12);
        hold(10);
        push(16'hF531, 4'b1111, 4'b0000, 1'b1);
        drive(4'b0111, 7'h0E);
        hold(10);
        check("t2_updates", n_updates - base_upd, 4);
        check("t2_frames",  n_frames - base_frm, 1);
        check("t2_hex",     hex_out, 16'hF531);

        // 3. Glitch to 00 inside a digit-1 window of 30: one capture of 3 only
        base_upd = n_updates;
        push(16'hF531, 4'b1111, 4'b0000, 1'b0);
        drive(4'b1101, 7'h30);
        hold(3);
        drive(4'b1101, 7'h00);
        hold(2);
        drive(4'b1101, 7'h30);
        hold(8);
        check("t3_updates", n_updates - base_upd, 1);

        // 4. Blank on digit 2 is illegal, then a legal 19 recovers it
        push(16'hF531, 4'b1011, 4'b0100, 1'b0);
        drive(4'b1011, 7'h7F);
        hold(10);
        check("t4_err_blank",   digit_err,   4'b0100);
        check("t4_nib_blank",   hex_out[11:8], 4'h5);
        push(16'hF431, 4'b1111, 4'b0000, 1'b0);
        drive(4'b1011, 7'h19);
        hold(10);
        check("t4_valid_legal", digit_valid, 4'b1111);

        // 5. Two strobes low: never captures
        base_upd = n_updates;
        drive(4'b1100, 7'h40);
        hold(20);
        check("t5_updates", n_updates - base_upd, 0);
        check("t5_hex",     hex_out,     16'hF431);
        check("t5_valid",   digit_valid, 4'b1111);
        check("t5_err",     digit_err,   4'b0000);

        // 6. Reset one cycle before capture, then full latency after release
        drive(4'b1110, 7'h79);
        hold(6);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(16'h0001, 4'b0001, 4'b0000, 1'b0);
        measure_latency("t6_latency", 20);
        hold(5);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
